// File: rtl/regfile_write_arbiter.sv
// Single write port owner for the register file: clear sequence on regs 1..N-1, then arbitrates two requesters (REGARB_ROUNDROBIN_EN selects round-robin, else fixed priority to requester 0).
// Latency: accept->RegWrite is 1 cycle (registered write stage); clear issues one write per cycle.
// Backpressure: ReqNReady is combinational, low during CLEAR and in the cycle ClearReq is seen in RUN.
module regfile_write_arbiter #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 5,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  ClearReq,
    output logic                  Busy,
    output logic                  ClearDone,
    input  logic                  Req0Valid,
    input  logic [ADDR_WIDTH-1:0] Req0Addr,
    input  logic [DATA_WIDTH-1:0] Req0Data,
    output logic                  Req0Ready,
    input  logic                  Req1Valid,
    input  logic [ADDR_WIDTH-1:0] Req1Addr,
    input  logic [DATA_WIDTH-1:0] Req1Data,
    output logic                  Req1Ready,
    output logic [ADDR_WIDTH-1:0] WriteRegister,
    output logic [DATA_WIDTH-1:0] WriteData,
    output logic                  RegWrite
);

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDR_WIDTH-1:0]   clr_cnt;
    logic                    clr_last;
    logic                    xfer0;
    logic                    xfer1;

    assign clr_last = (clr_cnt == '1);
    assign xfer0    = Req0Valid && Req0Ready;
    assign xfer1    = Req1Valid && Req1Ready;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= S_CLEAR;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_CLEAR: if (clr_last) state_nxt = S_RUN;
            S_RUN:   if (ClearReq) state_nxt = S_CLEAR;
            default: state_nxt = S_CLEAR;
        endcase
    end

`ifdef REGARB_ROUNDROBIN_EN
    // 1 means requester 1 was granted most recently, so requester 0 wins a tie.
    logic last_grant;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)   last_grant <= 1'b1;
        else if (xfer0) last_grant <= 1'b0;
        else if (xfer1) last_grant <= 1'b1;
    end

    always_comb begin
        Busy      = (state == S_CLEAR);
        Req0Ready = 1'b0;
        Req1Ready = 1'b0;
        if (state == S_RUN && !ClearReq) begin
            Req0Ready = Req0Valid && (!Req1Valid || last_grant);
            Req1Ready = Req1Valid && (!Req0Valid || !last_grant);
        end
    end
`else
    always_comb begin
        Busy      = (state == S_CLEAR);
        Req0Ready = 1'b0;
        Req1Ready = 1'b0;
        if (state == S_RUN && !ClearReq) begin
            Req0Ready = Req0Valid;
            Req1Ready = Req1Valid && !Req0Valid;
        end
    end
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)               clr_cnt <= ADDR_WIDTH'(1);
        else if (state == S_CLEAR)  clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
        else if (ClearReq)          clr_cnt <= ADDR_WIDTH'(1);
    end

    // Writes to register 0 are accepted but never reach the regfile.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            WriteRegister <= '0;
            WriteData     <= '0;
            RegWrite      <= 1'b0;
            ClearDone     <= 1'b0;
        end else begin
            ClearDone <= (state == S_CLEAR) && clr_last;
            RegWrite  <= 1'b0;
            if (state == S_CLEAR) begin
                WriteRegister <= clr_cnt;
                WriteData     <= CLEAR_VALUE;
                RegWrite      <= 1'b1;
            end else if (xfer0) begin
                if (Req0Addr != '0) begin
                    WriteRegister <= Req0Addr;
                    WriteData     <= Req0Data;
                    RegWrite      <= 1'b1;
                end
            end else if (xfer1) begin
                if (Req1Addr != '0) begin
                    WriteRegister <= Req1Addr;
                    WriteData     <= Req1Data;
                    RegWrite      <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_regfile_write_arbiter;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam logic [DW-1:0] CV = '0;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clr = 1'b0;
    logic          v0 = 1'b0, v1 = 1'b0;
    logic [AW-1:0] a0 = '0, a1 = '0;
    logic [DW-1:0] d0 = '0, d1 = '0;
    logic          busy, done, r0, r1, we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;

    int n_cmp = 0;
    int n_bad = 0;

    regfile_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CLEAR_VALUE(CV)) dut (
        .Clk(clk), .Reset_n(rst_n), .ClearReq(clr), .Busy(busy), .ClearDone(done),
        .Req0Valid(v0), .Req0Addr(a0), .Req0Data(d0), .Req0Ready(r0),
        .Req1Valid(v1), .Req1Addr(a1), .Req1Data(d1), .Req1Ready(r1),
        .WriteRegister(wa), .WriteData(wd), .RegWrite(we)
    );

    always #5 clk = ~clk;

    // Behavioural model: clearing flag, next register to clear, last granted requester, expected write stage.
    bit          m_clear;
    int          m_idx;
    int          m_last;
    bit          m_we;
    bit          m_done;
    int          m_wa;
    logic [DW-1:0] m_wd;

    task automatic model_reset();
        m_clear = 1; m_idx = 1; m_last = 1; m_we = 0; m_done = 0; m_wa = 0; m_wd = '0;
    endtask

    function automatic bit exp_rdy0();
        if (!rst_n || m_clear || clr || !v0) return 1'b0;
`ifdef REGARB_ROUNDROBIN_EN
        return !v1 || (m_last == 1);
`else
        return 1'b1;
`endif
    endfunction

    function automatic bit exp_rdy1();
        if (!rst_n || m_clear || clr || !v1) return 1'b0;
`ifdef REGARB_ROUNDROBIN_EN
        return !v0 || (m_last == 0);
`else
        return !v0;
`endif
    endfunction

    // Advances one clock and the model with it; inputs seen at the edge are those driven before the call.
    task automatic tick();
        bit g0, g1;
        g0 = exp_rdy0();
        g1 = exp_rdy1();
        @(posedge clk);
        if (!rst_n) model_reset();
        else if (m_clear) begin
            m_we = 1; m_wa = m_idx; m_wd = CV; m_done = (m_idx == 2**AW - 1);
            if (m_done) m_clear = 0; else m_idx++;
        end else begin
            m_done = 0; m_we = 0;
            if (clr) begin
                m_clear = 1; m_idx = 1;
            end else if (g0) begin
                m_last = 0;
                if (a0 != 0) begin m_we = 1; m_wa = int'(a0); m_wd = d0; end
            end else if (g1) begin
                m_last = 1;
                if (a1 != 0) begin m_we = 1; m_wa = int'(a1); m_wd = d1; end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        v0 = 1; a0 = 5; d0 = 1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (we !== 1'b0) begin n_bad++; $display("FAIL rst_regwrite: got %0b want 0", we); end
        n_cmp++; if (wa !== '0) begin n_bad++; $display("FAIL rst_wreg: got %0d want 0", wa); end
        n_cmp++; if (wd !== '0) begin n_bad++; $display("FAIL rst_wdata: got %0d want 0", wd); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %0b want 0", done); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rst_busy: got %0b want 1", busy); end
        n_cmp++; if (r0 !== 1'b0) begin n_bad++; $display("FAIL rst_ready0: got %0b want 0", r0); end
        v0 = 0;
        rst_n = 1;
    endtask

    task automatic test_boot_clear();
        for (int i = 1; i <= 31; i++) begin
            @(negedge clk);
            n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL boot_busy[%0d]: got %0b want 1", i, busy); end
            if (i > 1) begin
                n_cmp++; if (we !== 1'b1 || wa !== AW'(i - 1) || wd !== CV)
                    begin n_bad++; $display("FAIL boot_write[%0d]: got we=%0b reg=%0d data=%0d want we=1 reg=%0d data=%0d", i, we, wa, wd, i - 1, CV); end
                n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL boot_done_early[%0d]: got %0b want 0", i, done); end
            end
            tick();
        end
        @(negedge clk);
        n_cmp++; if (we !== 1'b1 || wa !== AW'(31)) begin n_bad++; $display("FAIL boot_last: got we=%0b reg=%0d want we=1 reg=31", we, wa); end
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL boot_done: got %0b want 1", done); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL boot_busy_end: got %0b want 0", busy); end
        tick();
        @(negedge clk);
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL boot_done_pulse: got %0b want 0", done); end
        n_cmp++; if (we !== 1'b0) begin n_bad++; $display("FAIL boot_idle_we: got %0b want 0", we); end
        tick();
    endtask

    task automatic test_single_write();
        v0 = 1; a0 = 5; d0 = 42;
        @(negedge clk);
        n_cmp++; if (r0 !== 1'b1 || r1 !== 1'b0) begin n_bad++; $display("FAIL single_ready: got r0=%0b r1=%0b want r0=1 r1=0", r0, r1); end
        tick();
        v0 = 0;
        @(negedge clk);
        n_cmp++; if (we !== 1'b1 || wa !== AW'(5) || wd !== 42)
            begin n_bad++; $display("FAIL single_write: got we=%0b reg=%0d data=%0d want we=1 reg=5 data=42", we, wa, wd); end
        tick();
        @(negedge clk);
        n_cmp++; if (we !== 1'b0) begin n_bad++; $display("FAIL single_after: got %0b want 0", we); end
        tick();
    endtask

    task automatic test_reg0();
        v1 = 1; a1 = 0; d1 = 15;
        @(negedge clk);
        n_cmp++; if (r1 !== 1'b1) begin n_bad++; $display("FAIL reg0_ready: got %0b want 1", r1); end
        tick();
        v1 = 0;
        @(negedge clk);
        n_cmp++; if (we !== 1'b0) begin n_bad++; $display("FAIL reg0_regwrite: got %0b want 0", we); end
        tick();
    endtask

    task automatic test_contention();
        int prev;
        bit w0;
        prev = -1;
        v0 = 1; a0 = 3; d0 = 10; v1 = 1; a1 = 4; d1 = 20;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
`ifdef REGARB_ROUNDROBIN_EN
            w0 = (k % 2 == 0);
`else
            w0 = 1'b1;
`endif
            n_cmp++; if (r0 !== w0 || r1 !== !w0)
                begin n_bad++; $display("FAIL contend_grant[%0d]: got r0=%0b r1=%0b want r0=%0b r1=%0b", k, r0, r1, w0, !w0); end
            if (prev >= 0) begin
                n_cmp++; if (we !== 1'b1 || wa !== AW'(prev))
                    begin n_bad++; $display("FAIL contend_write[%0d]: got we=%0b reg=%0d want we=1 reg=%0d", k, we, wa, prev); end
            end
            prev = w0 ? 3 : 4;
            tick();
        end
        v0 = 0; v1 = 0;
        @(negedge clk);
        n_cmp++; if (we !== 1'b1 || wa !== AW'(prev) || wd !== ((prev == 3) ? 10 : 20))
            begin n_bad++; $display("FAIL contend_last: got we=%0b reg=%0d data=%0d want reg=%0d", we, wa, wd, prev); end
        tick();
    endtask

    task automatic test_clear_req();
        int cnt;
        v0 = 1; a0 = 7; d0 = 99; clr = 1;
        @(negedge clk);
        n_cmp++; if (r0 !== 1'b0) begin n_bad++; $display("FAIL creq_ready_gate: got %0b want 0", r0); end
        tick();
        clr = 0;
        @(negedge clk);
        n_cmp++; if (we !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL creq_enter: got we=%0b busy=%0b want we=0 busy=1", we, busy); end
        cnt = 0;
        while (cnt < 40) begin
            n_cmp++; if (r0 !== 1'b0) begin n_bad++; $display("FAIL creq_ready_clear[%0d]: got %0b want 0", cnt, r0); end
            tick();
            @(negedge clk);
            cnt++;
            if (done === 1'b1) break;
            n_cmp++; if (we !== 1'b1 || wa !== AW'(cnt)) begin n_bad++; $display("FAIL creq_write[%0d]: got we=%0b reg=%0d want we=1 reg=%0d", cnt, we, wa, cnt); end
        end
        n_cmp++; if (cnt != 31) begin n_bad++; $display("FAIL creq_length: got %0d want 31 clear cycles", cnt); end
        n_cmp++; if (r0 !== 1'b1) begin n_bad++; $display("FAIL creq_regrant: got %0b want 1", r0); end
        tick();
        v0 = 0;
        @(negedge clk);
        n_cmp++; if (we !== 1'b1 || wa !== AW'(7) || wd !== 99)
            begin n_bad++; $display("FAIL creq_write7: got we=%0b reg=%0d data=%0d want we=1 reg=7 data=99", we, wa, wd); end
        tick();
    endtask

    task automatic test_reset_mid_clear();
        clr = 1;
        tick();
        clr = 0;
        repeat (10) tick();
        n_cmp++; if (we !== 1'b1 || wa !== AW'(10)) begin n_bad++; $display("FAIL mid_pre: got we=%0b reg=%0d want we=1 reg=10", we, wa); end
        #2;
        rst_n = 0;
        #1;
        n_cmp++; if (we !== 1'b0 || wa !== '0 || wd !== '0)
            begin n_bad++; $display("FAIL mid_async: got we=%0b reg=%0d data=%0d want all 0", we, wa, wd); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy: got %0b want 1", busy); end
        tick();
        rst_n = 1;
        for (int i = 1; i <= 31; i++) begin
            tick();
            @(negedge clk);
            n_cmp++; if (we !== 1'b1 || wa !== AW'(i) || done !== (i == 31))
                begin n_bad++; $display("FAIL mid_restart[%0d]: got we=%0b reg=%0d done=%0b want we=1 reg=%0d done=%0b", i, we, wa, done, i, i == 31); end
        end
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            v0 = 1'($urandom_range(0, 1)); a0 = AW'($urandom_range(0, 31)); d0 = $urandom;
            v1 = 1'($urandom_range(0, 1)); a1 = AW'($urandom_range(0, 31)); d1 = $urandom;
            clr = ($urandom_range(0, 49) == 0);
            @(negedge clk);
            n_cmp++; if (r0 !== exp_rdy0() || r1 !== exp_rdy1())
                begin n_bad++; $display("FAIL rand_ready[%0d]: got r0=%0b r1=%0b want r0=%0b r1=%0b", c, r0, r1, exp_rdy0(), exp_rdy1()); end
            n_cmp++; if (we !== m_we || done !== m_done || busy !== m_clear)
                begin n_bad++; $display("FAIL rand_ctrl[%0d]: got we=%0b done=%0b busy=%0b want we=%0b done=%0b busy=%0b", c, we, done, busy, m_we, m_done, m_clear); end
            if (m_we) begin
                n_cmp++; if (wa !== AW'(m_wa) || wd !== m_wd)
                    begin n_bad++; $display("FAIL rand_write[%0d]: got reg=%0d data=%0h want reg=%0d data=%0h", c, wa, wd, m_wa, m_wd); end
            end
            tick();
        end
        v0 = 0; v1 = 0; clr = 0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_boot_clear();
        test_single_write();
        test_reg0();
        test_contention();
        test_clear_req();
        test_reset_mid_clear();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
